// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port synchronous data memory between the CPU
// MEM stage and the image coprocessor. The CPU is normally favoured. A coprocessor
// that has waited COP_STARVE_MAX cycles gets a priority window of up to
// COP_BURST_MAX grants.
// Optional build macro DMEM_ARB_STATS_EN adds the saturating wait/stall counters
// stat_cop_wait and stat_cpu_stall.
module dmem_arbiter #(
   parameter int ADDR_W         = 14,
   parameter int DATA_W         = 32,
   parameter int COP_STARVE_MAX = 8,
   parameter int COP_BURST_MAX  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_stall,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rvalid,
   input  logic              cop_req,
   input  logic              cop_we,
   input  logic [ADDR_W-1:0] cop_addr,
   input  logic [DATA_W-1:0] cop_wdata,
   output logic              cop_gnt,
   output logic [DATA_W-1:0] cop_rdata,
   output logic              cop_rvalid,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [15:0]       stat_cop_wait,
   output logic [15:0]       stat_cpu_stall
`endif
);

   localparam int SW = $clog2(COP_STARVE_MAX + 1);
   localparam int BW = $clog2(COP_BURST_MAX + 1);
   localparam logic [SW-1:0] STARVE_MAX_C = SW'(COP_STARVE_MAX);
   localparam logic [BW-1:0] BURST_MAX_C  = BW'(COP_BURST_MAX);

   typedef enum logic {CPU_PRI = 1'b0, COP_PRI = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
   logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
   logic            rd_cpu_q, rd_cpu_d;
   logic            rd_cop_q, rd_cop_d;
   logic            cpu_gnt;

   // Same-cycle grant: the side holding priority wins any collision.
   always_comb begin
      cpu_gnt = 1'b0;
      cop_gnt = 1'b0;
      if (state_q == COP_PRI) begin
         cop_gnt = cop_req;
         cpu_gnt = cpu_req & ~cop_req;
      end else begin
         cpu_gnt = cpu_req;
         cop_gnt = cop_req & ~cpu_req;
      end
   end

   // Memory port mux; all-zero when idle so the port is quiet.
   always_comb begin
      mem_en    = cpu_gnt | cop_gnt;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (cpu_gnt) begin
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (cop_gnt) begin
         mem_we    = cop_we;
         mem_addr  = cop_addr;
         mem_wdata = cop_wdata;
      end
   end

   assign cpu_stall  = cpu_req & ~cpu_gnt;
   assign cpu_rvalid = rd_cpu_q;
   assign cop_rvalid = rd_cop_q;
   assign cpu_rdata  = mem_rdata;
   assign cop_rdata  = mem_rdata;

   // Priority FSM, starvation/burst counters and read-return tags.
   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      burst_cnt_d  = burst_cnt_q;
      rd_cpu_d     = cpu_gnt & ~cpu_we;
      rd_cop_d     = cop_gnt & ~cop_we;
      case (state_q)
         CPU_PRI: begin
            burst_cnt_d = '0;
            if (cop_req && !cop_gnt) begin
               if (starve_cnt_q != STARVE_MAX_C)
                  starve_cnt_d = starve_cnt_q + SW'(1);
            end else begin
               starve_cnt_d = '0;
            end
            if (starve_cnt_d == STARVE_MAX_C)
               state_d = COP_PRI;
         end
         COP_PRI: begin
            if (!cop_req) begin
               state_d      = CPU_PRI;
               starve_cnt_d = '0;
               burst_cnt_d  = '0;
            end else if (cop_gnt) begin
               if (burst_cnt_q + BW'(1) == BURST_MAX_C) begin
                  state_d      = CPU_PRI;
                  starve_cnt_d = '0;
                  burst_cnt_d  = '0;
               end else begin
                  burst_cnt_d = burst_cnt_q + BW'(1);
               end
            end
         end
         default: begin
            state_d      = CPU_PRI;
            starve_cnt_d = '0;
            burst_cnt_d  = '0;
         end
      endcase
   end

   // State register; reset drops any in-flight read tag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= CPU_PRI;
         starve_cnt_q <= '0;
         burst_cnt_q  <= '0;
         rd_cpu_q     <= 1'b0;
         rd_cop_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         burst_cnt_q  <= burst_cnt_d;
         rd_cpu_q     <= rd_cpu_d;
         rd_cop_q     <= rd_cop_d;
      end
   end

`ifdef DMEM_ARB_STATS_EN
   logic [15:0] stat_cop_wait_q, stat_cop_wait_d;
   logic [15:0] stat_cpu_stall_q, stat_cpu_stall_d;

   // Saturating event counters for coprocessor wait and CPU stall cycles.
   always_comb begin
      stat_cop_wait_d  = stat_cop_wait_q;
      stat_cpu_stall_d = stat_cpu_stall_q;
      if (cop_req && !cop_gnt && stat_cop_wait_q != 16'hFFFF)
         stat_cop_wait_d = stat_cop_wait_q + 16'd1;
      if (cpu_stall && stat_cpu_stall_q != 16'hFFFF)
         stat_cpu_stall_d = stat_cpu_stall_q + 16'd1;
   end

   // Statistics registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_cop_wait_q  <= '0;
         stat_cpu_stall_q <= '0;
      end else begin
         stat_cop_wait_q  <= stat_cop_wait_d;
         stat_cpu_stall_q <= stat_cpu_stall_d;
      end
   end

   assign stat_cop_wait  = stat_cop_wait_q;
   assign stat_cpu_stall = stat_cpu_stall_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a one-cycle-latency memory model.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [13:0] cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic        cpu_stall, cpu_rvalid;
   logic [31:0] cpu_rdata;
   logic        cop_req = 1'b0, cop_we = 1'b0;
   logic [13:0] cop_addr = '0;
   logic [31:0] cop_wdata = '0;
   logic        cop_gnt, cop_rvalid;
   logic [31:0] cop_rdata;
   logic        mem_en, mem_we;
   logic [13:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;

   int n_pass  = 0;
   int n_total = 0;

`ifdef DMEM_ARB_STATS_EN
   logic [15:0] stat_cop_wait, stat_cpu_stall;
   logic        s_req = 1'b0;
   logic        s_cpu_stall, s_cpu_rvalid, s_cop_gnt, s_cop_rvalid;
   logic        s_mem_en, s_mem_we;
   logic [13:0] s_mem_addr;
   logic [31:0] s_cpu_rdata, s_cop_rdata, s_mem_wdata;
   logic [15:0] s_stat_cop_wait, s_stat_cpu_stall;
`endif

   dmem_arbiter dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
      .cop_req(cop_req), .cop_we(cop_we), .cop_addr(cop_addr), .cop_wdata(cop_wdata),
      .cop_gnt(cop_gnt), .cop_rdata(cop_rdata), .cop_rvalid(cop_rvalid),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
      ,
      .stat_cop_wait(stat_cop_wait), .stat_cpu_stall(stat_cpu_stall)
`endif
   );

`ifdef DMEM_ARB_STATS_EN
   // Second instance with a long priority window, used to push the stall counter to saturation.
   dmem_arbiter #(.COP_STARVE_MAX(1), .COP_BURST_MAX(65535)) u_sat (
      .clk(clk), .rst(rst),
      .cpu_req(s_req), .cpu_we(1'b0), .cpu_addr(14'd0), .cpu_wdata(32'd0),
      .cpu_stall(s_cpu_stall), .cpu_rdata(s_cpu_rdata), .cpu_rvalid(s_cpu_rvalid),
      .cop_req(s_req), .cop_we(1'b0), .cop_addr(14'd1), .cop_wdata(32'd0),
      .cop_gnt(s_cop_gnt), .cop_rdata(s_cop_rdata), .cop_rvalid(s_cop_rvalid),
      .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
      .mem_rdata(32'd0),
      .stat_cop_wait(s_stat_cop_wait), .stat_cpu_stall(s_stat_cpu_stall)
   );
`endif

   always #5 clk = ~clk;

   // Memory model: unwritten words read as {24'h5A5A00, addr[7:0]}, 0x010 preloaded with DEADBEEF.
   logic [31:0] mem_data [0:255];
   logic        mem_written [0:255] = '{default: 1'b0};

   function automatic logic [31:0] mem_init(input logic [7:0] a);
      if (a == 8'h10) return 32'hDEADBEEF;
      return {24'h5A5A00, a};
   endfunction

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            mem_data[mem_addr[7:0]]    <= mem_wdata;
            mem_written[mem_addr[7:0]] <= 1'b1;
         end else begin
            mem_rdata <= mem_written[mem_addr[7:0]] ? mem_data[mem_addr[7:0]] : mem_init(mem_addr[7:0]);
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_total++; if (cpu_rvalid !== 1'b0) $display("FAIL reset_cpu_rvalid: got %b want 0", cpu_rvalid); else n_pass++;
      n_total++; if (cop_rvalid !== 1'b0) $display("FAIL reset_cop_rvalid: got %b want 0", cop_rvalid); else n_pass++;
      n_total++; if (mem_en !== 1'b0) $display("FAIL reset_mem_en: got %b want 0", mem_en); else n_pass++;
      n_total++; if (mem_addr !== 14'h0) $display("FAIL reset_mem_addr_idle: got %h want 0", mem_addr); else n_pass++;
      cpu_req = 1'b1; cop_req = 1'b1; cpu_addr = 14'h011; cop_addr = 14'h022;
      #2;
      n_total++; if (mem_addr !== 14'h011) $display("FAIL reset_prio_addr: got %h want 011", mem_addr); else n_pass++;
      n_total++; if (cop_gnt !== 1'b0) $display("FAIL reset_prio_cop_gnt: got %b want 0", cop_gnt); else n_pass++;
      cpu_req = 1'b0; cop_req = 1'b0;
      next_cycle();
      rst = 1'b0;
      $display("test_reset done");
   endtask

   task automatic test_cpu_load();
      next_cycle();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h010;
      #2;
      n_total++; if (mem_en !== 1'b1) $display("FAIL load_mem_en: got %b want 1", mem_en); else n_pass++;
      n_total++; if (mem_we !== 1'b0) $display("FAIL load_mem_we: got %b want 0", mem_we); else n_pass++;
      n_total++; if (mem_addr !== 14'h010) $display("FAIL load_mem_addr: got %h want 010", mem_addr); else n_pass++;
      n_total++; if (cpu_stall !== 1'b0) $display("FAIL load_stall: got %b want 0", cpu_stall); else n_pass++;
      next_cycle();
      cpu_req = 1'b0;
      #2;
      n_total++; if (cpu_rvalid !== 1'b1) $display("FAIL load_rvalid: got %b want 1", cpu_rvalid); else n_pass++;
      n_total++; if (cpu_rdata !== 32'hDEADBEEF) $display("FAIL load_rdata: got %h want deadbeef", cpu_rdata); else n_pass++;
      n_total++; if (cop_rvalid !== 1'b0) $display("FAIL load_cop_rvalid: got %b want 0", cop_rvalid); else n_pass++;
      $display("test_cpu_load: addr 010 -> %h", cpu_rdata);
   endtask

   task automatic test_contention();
      next_cycle();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h020; cpu_wdata = 32'hA5A5A5A5;
      cop_req = 1'b1; cop_we = 1'b0; cop_addr = 14'h020;
      #2;
      n_total++; if (cop_gnt !== 1'b0) $display("FAIL cont_cop_gnt0: got %b want 0", cop_gnt); else n_pass++;
      n_total++; if (cpu_stall !== 1'b0) $display("FAIL cont_stall: got %b want 0", cpu_stall); else n_pass++;
      n_total++; if (mem_we !== 1'b1) $display("FAIL cont_mem_we: got %b want 1", mem_we); else n_pass++;
      n_total++; if (mem_wdata !== 32'hA5A5A5A5) $display("FAIL cont_wdata: got %h want a5a5a5a5", mem_wdata); else n_pass++;
      next_cycle();
      cpu_req = 1'b0;
      #2;
      n_total++; if (cop_gnt !== 1'b1) $display("FAIL cont_cop_gnt1: got %b want 1", cop_gnt); else n_pass++;
      n_total++; if (mem_we !== 1'b0) $display("FAIL cont_cop_mem_we: got %b want 0", mem_we); else n_pass++;
      next_cycle();
      cop_req = 1'b0;
      #2;
      n_total++; if (cop_rvalid !== 1'b1) $display("FAIL cont_cop_rvalid: got %b want 1", cop_rvalid); else n_pass++;
      n_total++; if (cop_rdata !== 32'hA5A5A5A5) $display("FAIL cont_cop_rdata: got %h want a5a5a5a5", cop_rdata); else n_pass++;
      n_total++; if (cpu_rvalid !== 1'b0) $display("FAIL cont_cpu_rvalid: got %b want 0", cpu_rvalid); else n_pass++;
      $display("test_contention: cop read after cpu store -> %h", cop_rdata);
   endtask

   task automatic test_starvation();
      logic        exp_gnt;
      logic [15:0] w0, s0;
      w0 = '0; s0 = '0;
      next_cycle();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h030; cpu_wdata = 32'h11112222;
      cop_req = 1'b1; cop_we = 1'b0; cop_addr = 14'h040;
`ifdef DMEM_ARB_STATS_EN
      #2;
      w0 = stat_cop_wait; s0 = stat_cpu_stall;
      #0;
`endif
      for (int i = 0; i < 12; i++) begin
         if (i > 0) next_cycle();
         else #1;
         #1;
         exp_gnt = (i >= 8);
         n_total++; if (cop_gnt !== exp_gnt) $display("FAIL starve_cop_gnt[%0d]: got %b want %b", i, cop_gnt, exp_gnt); else n_pass++;
         n_total++; if (cpu_stall !== exp_gnt) $display("FAIL starve_cpu_stall[%0d]: got %b want %b", i, cpu_stall, exp_gnt); else n_pass++;
         if (i >= 9) begin
            n_total++; if (cop_rdata !== 32'h5A5A0040) $display("FAIL starve_cop_rdata[%0d]: got %h want 5a5a0040", i, cop_rdata); else n_pass++;
         end
      end
      next_cycle();
      cop_req = 1'b0;
      #2;
      n_total++; if (cpu_stall !== 1'b0) $display("FAIL starve_return_stall: got %b want 0", cpu_stall); else n_pass++;
      n_total++; if (mem_addr !== 14'h030) $display("FAIL starve_return_addr: got %h want 030", mem_addr); else n_pass++;
`ifdef DMEM_ARB_STATS_EN
      n_total++; if (stat_cop_wait - w0 !== 16'd8) $display("FAIL stat_cop_wait: got %0d want 8", stat_cop_wait - w0); else n_pass++;
      n_total++; if (stat_cpu_stall - s0 !== 16'd4) $display("FAIL stat_cpu_stall: got %0d want 4", stat_cpu_stall - s0); else n_pass++;
`endif
      next_cycle();
      cpu_req = 1'b0;
      $display("test_starvation: 8 denials, 4 cop grants, back to cpu");
   endtask

   task automatic test_cop_early_drop();
      next_cycle();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h012;
      cop_req = 1'b1; cop_we = 1'b0; cop_addr = 14'h044;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) next_cycle();
         #2;
         n_total++; if (cop_gnt !== (i >= 8)) $display("FAIL drop_cop_gnt[%0d]: got %b want %b", i, cop_gnt, (i >= 8)); else n_pass++;
      end
      next_cycle();
      cop_req = 1'b0;
      #2;
      n_total++; if (cpu_stall !== 1'b0) $display("FAIL drop_stall: got %b want 0", cpu_stall); else n_pass++;
      n_total++; if (mem_addr !== 14'h012) $display("FAIL drop_addr: got %h want 012", mem_addr); else n_pass++;
      next_cycle();
      cop_req = 1'b1;
      #2;
      n_total++; if (cop_gnt !== 1'b0) $display("FAIL drop_cpu_pri: got %b want 0", cop_gnt); else n_pass++;
      n_total++; if (dut.starve_cnt_q !== '0) $display("FAIL drop_starve_cnt: got %0d want 0", dut.starve_cnt_q); else n_pass++;
      next_cycle();
      cpu_req = 1'b0; cop_req = 1'b0;
      $display("test_cop_early_drop: returned to cpu priority after 2 cop grants");
   endtask

   task automatic test_reset_inflight();
      next_cycle();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h013;
      cop_req = 1'b1; cop_we = 1'b0; cop_addr = 14'h045;
      for (int i = 0; i < 9; i++) begin
         if (i > 0) next_cycle();
      end
      #2;
      n_total++; if (cop_gnt !== 1'b1) $display("FAIL rstfl_cop_gnt: got %b want 1", cop_gnt); else n_pass++;
      #1;
      rst = 1'b1;
      next_cycle();
      cpu_req = 1'b0; cop_req = 1'b0;
      rst = 1'b0;
      #2;
      n_total++; if (cop_rvalid !== 1'b0) $display("FAIL rstfl_cop_rvalid: got %b want 0", cop_rvalid); else n_pass++;
      cpu_req = 1'b1; cop_req = 1'b1;
      #1;
      n_total++; if (cop_gnt !== 1'b0) $display("FAIL rstfl_state: got cop_gnt %b want 0", cop_gnt); else n_pass++;
      n_total++; if (cpu_stall !== 1'b0) $display("FAIL rstfl_stall: got %b want 0", cpu_stall); else n_pass++;
      next_cycle();
      cpu_req = 1'b0; cop_req = 1'b0;
      #2;
      n_total++; if (cop_rvalid !== 1'b0) $display("FAIL rstfl_cop_rvalid2: got %b want 0", cop_rvalid); else n_pass++;
      $display("test_reset_inflight: in-flight cop read dropped");
   endtask

   task automatic test_back_to_back();
      next_cycle();
      cop_req = 1'b1; cop_we = 1'b1; cop_addr = 14'h050; cop_wdata = 32'hCAFEF00D;
      #2;
      n_total++; if (cop_gnt !== 1'b1) $display("FAIL b2b_cop_gnt: got %b want 1", cop_gnt); else n_pass++;
      n_total++; if (mem_wdata !== 32'hCAFEF00D) $display("FAIL b2b_cop_wdata: got %h want cafef00d", mem_wdata); else n_pass++;
      next_cycle();
      cop_req = 1'b0; cop_we = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h050;
      #2;
      n_total++; if (mem_en !== 1'b1) $display("FAIL b2b_mem_en: got %b want 1", mem_en); else n_pass++;
      next_cycle();
      cpu_addr = 14'h051;
      #2;
      n_total++; if (cpu_rvalid !== 1'b1) $display("FAIL b2b_rvalid0: got %b want 1", cpu_rvalid); else n_pass++;
      n_total++; if (cpu_rdata !== 32'hCAFEF00D) $display("FAIL b2b_rdata0: got %h want cafef00d", cpu_rdata); else n_pass++;
      next_cycle();
      cpu_req = 1'b0;
      #2;
      n_total++; if (cpu_rvalid !== 1'b1) $display("FAIL b2b_rvalid1: got %b want 1", cpu_rvalid); else n_pass++;
      n_total++; if (cpu_rdata !== 32'h5A5A0051) $display("FAIL b2b_rdata1: got %h want 5a5a0051", cpu_rdata); else n_pass++;
      next_cycle();
      #2;
      n_total++; if (cpu_rvalid !== 1'b0) $display("FAIL b2b_rvalid_idle: got %b want 0", cpu_rvalid); else n_pass++;
      $display("test_back_to_back: cop write then two cpu loads");
   endtask

`ifdef DMEM_ARB_STATS_EN
   task automatic test_stat_saturation();
      next_cycle();
      s_req = 1'b1;
      repeat (70100) @(posedge clk);
      #1;
      s_req = 1'b0;
      #2;
      n_total++; if (s_stat_cpu_stall !== 16'hFFFF) $display("FAIL stat_stall_sat: got %h want ffff", s_stat_cpu_stall); else n_pass++;
      $display("test_stat_saturation: stall counter %h", s_stat_cpu_stall);
   endtask
`endif

   initial begin
      test_reset();
      test_cpu_load();
      test_contention();
      test_starvation();
      test_cop_early_drop();
      test_reset_inflight();
      test_back_to_back();
`ifdef DMEM_ARB_STATS_EN
      test_stat_saturation();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
